// File: rtl/dbns_greedy_converter_if.sv
// rtl/dbns_greedy_converter_if.sv - operand and term stream handshakes of the DBNS greedy converter
interface dbns_greedy_converter_if #(
    parameter int NUM_BITS = 8,
    parameter int MAX_B3   = 2
);
    localparam int A_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int B_W = ($clog2(MAX_B3 + 1) > 1) ? $clog2(MAX_B3 + 1) : 1;

    logic                in_valid;
    logic                in_ready;
    logic [NUM_BITS-1:0] in_data;
    logic                term_valid;
    logic                term_ready;
    logic [A_W-1:0]      term_exp2;
    logic [B_W-1:0]      term_exp3;
    logic                term_last;

    // master is the converter side, slave is whoever feeds operands and takes terms
    modport master (
        input  in_valid, in_data, term_ready,
        output in_ready, term_valid, term_exp2, term_exp3, term_last
    );
    modport slave (
        output in_valid, in_data, term_ready,
        input  in_ready, term_valid, term_exp2, term_exp3, term_last
    );
endinterface

// File: rtl/dbns_greedy_converter.sv
// rtl/dbns_greedy_converter.sv - sequential greedy binary to 2^a*3^b term converter
module dbns_greedy_converter #(
    parameter int NUM_BITS  = 8,
    parameter int MAX_B3    = 2,
    parameter int MAX_TERMS = 8,
    localparam int A_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1,
    localparam int B_W = ($clog2(MAX_B3 + 1) > 1) ? $clog2(MAX_B3 + 1) : 1,
    localparam int C_W = $clog2(MAX_TERMS + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    dbns_greedy_converter_if.master  bus,
    output logic                     done,
    output logic [C_W-1:0]           term_count,
    output logic                     overflow,
    output logic [NUM_BITS-1:0]      residue,
    output logic                     busy
);
    localparam int P_W = 64;

    typedef enum logic [1:0] {IDLE, SEARCH, EMIT, FINISH} state_t;

    state_t              state, state_next;
    logic [NUM_BITS-1:0] residue_q, best_val, res_next;
    logic [A_W-1:0]      best_a, cand_a;
    logic [B_W-1:0]      best_b, b_idx;
    logic [C_W-1:0]      count, count_inc;
    logic [P_W-1:0]      p3;
    logic [NUM_BITS-1:0] cand_val;
    logic                cand_ok, last_term, b_end;

    function automatic logic [P_W-1:0] pow3(input logic [B_W-1:0] b);
        logic [P_W-1:0] p;
        p = 64'd1;
        for (int i = 0; i < MAX_B3; i++)
            if (i < int'(b)) p = p * 64'd3;
        return p;
    endfunction

    // Compare 3^b against residue>>a so the shifted power never has to be formed wide
    always_comb begin
        p3      = pow3(b_idx);
        cand_ok = 1'b0;
        cand_a  = '0;
        for (int a = 0; a < NUM_BITS; a++) begin
            if (P_W'(residue_q >> a) >= p3) begin
                cand_ok = 1'b1;
                cand_a  = A_W'(a);
            end
        end
        cand_val = p3[NUM_BITS-1:0] << cand_a;
    end

    assign res_next  = residue_q - best_val;
    assign count_inc = count + C_W'(1);
    assign last_term = (res_next == '0) || (count_inc == C_W'(MAX_TERMS));
    assign b_end     = (b_idx == B_W'(MAX_B3));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = (bus.in_data != '0) ? SEARCH : FINISH;
            SEARCH:  if (b_end) state_next = EMIT;
            EMIT:    if (bus.term_ready) state_next = last_term ? FINISH : SEARCH;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready   = (state == IDLE);
        bus.term_valid = (state == EMIT);
        bus.term_exp2  = (state == EMIT) ? best_a : '0;
        bus.term_exp3  = (state == EMIT) ? best_b : '0;
        bus.term_last  = (state == EMIT) && last_term;
        done           = (state == FINISH);
        busy           = (state != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            residue_q  <= '0;
            best_val   <= '0;
            best_a     <= '0;
            best_b     <= '0;
            b_idx      <= '0;
            count      <= '0;
            term_count <= '0;
            overflow   <= 1'b0;
            residue    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    residue_q  <= bus.in_data;
                    count      <= '0;
                    term_count <= '0;
                    overflow   <= 1'b0;
                    residue    <= '0;
                    b_idx      <= '0;
                    best_val   <= '0;
                end
                SEARCH: begin
                    // values 2^a*3^b are unique, so strict greater-than never hides a tie
                    if (cand_ok && cand_val > best_val) begin
                        best_val <= cand_val;
                        best_a   <= cand_a;
                        best_b   <= b_idx;
                    end
                    b_idx <= b_end ? '0 : b_idx + B_W'(1);
                end
                EMIT: if (bus.term_ready) begin
                    residue_q <= res_next;
                    count     <= count_inc;
                    best_val  <= '0;
                    b_idx     <= '0;
                    if (last_term) begin
                        overflow   <= (res_next != '0);
                        residue    <= res_next;
                        term_count <= count_inc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dbns_greedy_converter.sv
// tb/tb_dbns_greedy_converter.sv - directed self-checking bench for dbns_greedy_converter
module tb_dbns_greedy_converter;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dbns_greedy_converter_if #(.NUM_BITS(8), .MAX_B3(2)) bus  ();
    dbns_greedy_converter_if #(.NUM_BITS(8), .MAX_B3(2)) bus2 ();

    logic       done, overflow, busy, done2, overflow2, busy2;
    logic [3:0] term_count;
    logic [1:0] term_count2;
    logic [7:0] residue, residue2;

    dbns_greedy_converter #(.NUM_BITS(8), .MAX_B3(2), .MAX_TERMS(8)) dut (
        .clock(clock), .reset(reset), .bus(bus), .done(done), .term_count(term_count),
        .overflow(overflow), .residue(residue), .busy(busy)
    );
    dbns_greedy_converter #(.NUM_BITS(8), .MAX_B3(2), .MAX_TERMS(2)) dut2 (
        .clock(clock), .reset(reset), .bus(bus2), .done(done2), .term_count(term_count2),
        .overflow(overflow2), .residue(residue2), .busy(busy2)
    );

    int errors = 0;
    int checks = 0;

    int got_a[16], got_b[16], got_l[16];
    int n_terms, got_count, got_ovf, got_res;
    bit done_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run_op(input bit sel, input logic [7:0] val, input int stall);
        bit tv, tr, tl, held;
        int ta, tb_, hold_a, hold_b, stall_cnt;
        n_terms = 0; done_seen = 0; held = 0; stall_cnt = 0;
        @(negedge clock);
        if (sel) begin bus2.in_data = val; bus2.in_valid = 1; bus2.term_ready = (stall == 0); end
        else     begin bus.in_data  = val; bus.in_valid  = 1; bus.term_ready  = (stall == 0); end
        @(negedge clock);
        bus.in_valid = 0; bus2.in_valid = 0;
        for (int cyc = 0; cyc < 300 && !done_seen; cyc++) begin
            tv  = sel ? bus2.term_valid : bus.term_valid;
            tr  = sel ? bus2.term_ready : bus.term_ready;
            tl  = sel ? bus2.term_last  : bus.term_last;
            ta  = sel ? int'(bus2.term_exp2) : int'(bus.term_exp2);
            tb_ = sel ? int'(bus2.term_exp3) : int'(bus.term_exp3);
            if (tv) begin
                if (!tr) begin
                    if (held) begin
                        check("hold_exp2", ta, hold_a);
                        check("hold_exp3", tb_, hold_b);
                    end else begin
                        held = 1; hold_a = ta; hold_b = tb_;
                    end
                    stall_cnt++;
                    if (stall_cnt >= stall) begin
                        if (sel) bus2.term_ready = 1; else bus.term_ready = 1;
                        tr = 1;
                    end
                end
                if (tr) begin
                    if (n_terms < 16) begin
                        got_a[n_terms] = ta; got_b[n_terms] = tb_; got_l[n_terms] = int'(tl);
                    end
                    n_terms++;
                end
            end
            if (sel ? done2 : done) begin
                done_seen = 1;
                got_count = sel ? int'(term_count2) : int'(term_count);
                got_ovf   = sel ? int'(overflow2)   : int'(overflow);
                got_res   = sel ? int'(residue2)    : int'(residue);
            end else begin
                @(negedge clock);
            end
        end
        if (!done_seen) check("done_timeout", 0, 1);
        bus.term_ready = 1; bus2.term_ready = 1;
    endtask

    task automatic check_terms(input string tag, input int n, input int ea[8], input int eb[8]);
        check({tag, "_nterms"}, n_terms, n);
        for (int i = 0; i < n && i < n_terms; i++) begin
            check($sformatf("%s_a%0d", tag, i), got_a[i], ea[i]);
            check($sformatf("%s_b%0d", tag, i), got_b[i], eb[i]);
            check($sformatf("%s_last%0d", tag, i), got_l[i], (i == n - 1) ? 1 : 0);
        end
    endtask

    initial begin
        reset = 1;
        bus.in_valid = 0;  bus.in_data = '0;  bus.term_ready = 1;
        bus2.in_valid = 0; bus2.in_data = '0; bus2.term_ready = 1;
        repeat (2) @(negedge clock);
        reset = 0;
        @(negedge clock);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_term_valid", bus.term_valid, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_count", term_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_residue", residue, 0);

        // T1
        run_op(0, 8'd100, 0);
        check_terms("t1", 2, '{5, 2, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0});
        check("t1_count", got_count, 2);
        check("t1_ovf", got_ovf, 0);
        check("t1_res", got_res, 0);

        // T2
        run_op(0, 8'd255, 0);
        check_terms("t2", 4, '{6, 4, 2, 0, 0, 0, 0, 0}, '{1, 1, 1, 1, 0, 0, 0, 0});
        check("t2_count", got_count, 4);
        check("t2_res", got_res, 0);

        // T3
        run_op(0, 8'd1, 0);
        check_terms("t3a", 1, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
        check("t3a_count", got_count, 1);
        run_op(0, 8'd0, 0);
        check("t3b_nterms", n_terms, 0);
        check("t3b_count", got_count, 0);
        check("t3b_ovf", got_ovf, 0);

        // T4
        run_op(1, 8'd255, 0);
        check_terms("t4", 2, '{6, 4, 0, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0, 0, 0});
        check("t4_count", got_count, 2);
        check("t4_ovf", got_ovf, 1);
        check("t4_res", got_res, 15);
        @(negedge clock);
        check("t4_hold_ovf", overflow2, 1);
        check("t4_hold_res", residue2, 15);

        // T5
        run_op(0, 8'd100, 5);
        check_terms("t5", 2, '{5, 2, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0, 0});
        check("t5_count", got_count, 2);

        // T6
        @(negedge clock);
        bus.in_data = 8'd255; bus.in_valid = 1; bus.term_ready = 0;
        @(negedge clock);
        bus.in_valid = 0;
        begin
            bit seen;
            seen = 0;
            for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
                if (bus.term_valid) seen = 1;
                else @(negedge clock);
            end
            check("t6_reach_emit", seen, 1);
            check("t6_in_ready_busy", bus.in_ready, 0);
        end
        reset = 1;
        #1;
        check("t6_term_valid", bus.term_valid, 0);
        check("t6_in_ready", bus.in_ready, 1);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_count", term_count, 0);
        check("t6_exp2", bus.term_exp2, 0);
        @(negedge clock);
        reset = 0;
        bus.term_ready = 1;
        run_op(0, 8'd1, 0);
        check_terms("t6", 1, '{0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0});
        check("t6_count_after", got_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
